// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (CPU memory port) and mem_responder.
// err_o exists only when MEM_ALIGN_CHECK_EN is defined.
interface mem_responder_if #(
    parameter int WIDTH = 32
);
    logic             req_i;
    logic             we_i;
    logic [WIDTH-1:0] addr_i;
    logic [WIDTH-1:0] wdata_i;
    logic             ready_o;
    logic [WIDTH-1:0] rdata_o;
`ifdef MEM_ALIGN_CHECK_EN
    logic             err_o;

    modport master (output req_i, we_i, addr_i, wdata_i, input ready_o, rdata_o, err_o);
    modport slave  (input req_i, we_i, addr_i, wdata_i, output ready_o, rdata_o, err_o);
`else
    modport master (output req_i, we_i, addr_i, wdata_i, input ready_o, rdata_o);
    modport slave  (input req_i, we_i, addr_i, wdata_i, output ready_o, rdata_o);
`endif
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory target with a fixed number of wait states and a one-cycle ready pulse.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned accesses are suppressed and flagged on err_o).
module mem_responder #(
    parameter int WIDTH       = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic                  capture, access;
    logic                  lat_we;
    logic [DEPTH_LOG2-1:0] lat_idx;
    logic [WIDTH-1:0]      lat_wdata;
    logic [WIDTH-1:0]      rdata;
    logic                  acc_we, acc_ok;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [WIDTH-1:0]      acc_wdata;
    logic [WIDTH-1:0]      mem [DEPTH];

    // With zero wait states the access happens on the capture edge, so use the live bus then.
    assign acc_we    = (state == S_IDLE) ? bus.we_i : lat_we;
    assign acc_idx   = (state == S_IDLE) ? bus.addr_i[DEPTH_LOG2+1:2] : lat_idx;
    assign acc_wdata = (state == S_IDLE) ? bus.wdata_i : lat_wdata;

`ifdef MEM_ALIGN_CHECK_EN
    logic lat_mis, acc_mis;
    logic unused_addr_bits;

    assign acc_mis          = (state == S_IDLE) ? (bus.addr_i[1:0] != 2'b00) : lat_mis;
    assign acc_ok           = !acc_mis;
    assign bus.err_o        = (state == S_RESP) && lat_mis;
    assign unused_addr_bits = ^bus.addr_i[WIDTH-1:DEPTH_LOG2+2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_mis <= 1'b0;
        end else if (capture) begin
            lat_mis <= acc_mis;
        end
    end
`else
    logic unused_addr_bits;

    assign acc_ok           = 1'b1;
    assign unused_addr_bits = ^{bus.addr_i[WIDTH-1:DEPTH_LOG2+2], bus.addr_i[1:0]};
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        access     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_i) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        access     = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        cnt_next   = CNT_LOAD;
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    access     = 1'b1;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                lat_we    <= bus.we_i;
                lat_idx   <= bus.addr_i[DEPTH_LOG2+1:2];
                lat_wdata <= bus.wdata_i;
            end
            if (access && !acc_we && acc_ok) begin
                rdata <= mem[acc_idx];
            end
        end
    end

    // Storage is never reset; the rst term keeps an access from landing while reset is held.
    always_ff @(posedge clk) begin
        if (access && acc_we && acc_ok && rst) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.ready_o = (state == S_RESP);
    assign bus.rdata_o = rdata;
endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: a 2-wait-state and a 0-wait-state instance checked against a word-array model.
// Build with MEM_ALIGN_CHECK_EN defined to exercise the misalignment path.
module tb_mem_responder;
    localparam int WIDTH      = 32;
    localparam int DEPTH_LOG2 = 10;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [WIDTH-1:0] model_mem   [2][DEPTH];
    logic [WIDTH-1:0] model_rdata [2];

    always #5 clk = ~clk;

    mem_responder_if #(.WIDTH(WIDTH)) bus2 ();
    mem_responder_if #(.WIDTH(WIDTH)) bus0 ();

    mem_responder #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );
    mem_responder #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    function automatic int wait_of(input int sel);
        return (sel == 0) ? 2 : 0;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus2.ready_o : bus0.ready_o;
    endfunction

    function automatic logic [WIDTH-1:0] get_rdata(input int sel);
        return (sel == 0) ? bus2.rdata_o : bus0.rdata_o;
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    function automatic logic get_err(input int sel);
        return (sel == 0) ? bus2.err_o : bus0.err_o;
    endfunction
`endif

    task automatic drive(input int sel, input logic req, input logic we,
                         input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata);
        if (sel == 0) begin
            bus2.req_i = req; bus2.we_i = we; bus2.addr_i = addr; bus2.wdata_i = wdata;
        end else begin
            bus0.req_i = req; bus0.we_i = we; bus0.addr_i = addr; bus0.wdata_i = wdata;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One complete handshake; called just after a falling edge.
    task automatic applyStimulus(input int sel, input logic we,
                                 input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata);
        int   idx;
        int   cycles;
        logic mis;
        logic got;
        idx = int'((addr >> 2) % DEPTH);
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (addr % 4) != 0;
`endif
        if (!mis) begin
            if (we) model_mem[sel][idx] = wdata;
            else    model_rdata[sel]    = model_mem[sel][idx];
        end
        drive(sel, 1'b1, we, addr, wdata);
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 20) begin
            @(negedge clk);
            cycles++;
            got = get_ready(sel);
        end
        checkOutput(we ? "write_latency" : "read_latency", 32'(cycles), 32'(wait_of(sel) + 1));
        drive(sel, 1'b0, 1'b0, '0, '0);
        checkOutput("rdata", get_rdata(sel), model_rdata[sel]);
`ifdef MEM_ALIGN_CHECK_EN
        checkOutput("err", 32'(get_err(sel)), 32'(mis));
`endif
        @(negedge clk);
        checkOutput("ready_one_cycle", 32'(get_ready(sel)), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        $display("[TB] idle after reset");
        repeat (5) begin
            @(negedge clk);
            checkOutput("idle_ready_w2", 32'(bus2.ready_o), 32'd0);
            checkOutput("idle_rdata_w2", bus2.rdata_o, 32'd0);
            checkOutput("idle_ready_w0", 32'(bus0.ready_o), 32'd0);
            checkOutput("idle_rdata_w0", bus0.rdata_o, 32'd0);
        end

        $display("[TB] write then read back");
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 32'h10, 32'h0);
        checkOutput("readback_const", bus2.rdata_o, 32'hDEADBEEF);

        $display("[TB] address alias wrap");
        applyStimulus(0, 1'b1, 32'h1000, 32'hA5A5A5A5);
        applyStimulus(0, 1'b0, 32'h0, 32'h0);
        checkOutput("alias_const", bus2.rdata_o, 32'hA5A5A5A5);

        $display("[TB] reset during wait aborts write");
        applyStimulus(0, 1'b1, 32'h20, 32'hCAFEF00D);
        drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        @(posedge clk);
        #2 rst = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_ready", 32'(bus2.ready_o), 32'd0);
            checkOutput("abort_rdata", bus2.rdata_o, 32'd0);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_abort_ready", 32'(bus2.ready_o), 32'd0);
        end
        applyStimulus(0, 1'b0, 32'h20, 32'h0);
        checkOutput("abort_no_write", bus2.rdata_o, 32'hCAFEF00D);

        $display("[TB] zero wait states, back-to-back reads");
        applyStimulus(1, 1'b1, 32'h0, 32'h1);
        applyStimulus(1, 1'b1, 32'h4, 32'h2);
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("b2b_ready_1", 32'(bus0.ready_o), 32'd1);
        checkOutput("b2b_rdata_1", bus0.rdata_o, 32'h1);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        checkOutput("b2b_gap", 32'(bus0.ready_o), 32'd0);
        @(negedge clk);
        checkOutput("b2b_ready_2", 32'(bus0.ready_o), 32'd1);
        checkOutput("b2b_rdata_2", bus0.rdata_o, 32'h2);
        drive(1, 1'b0, 1'b0, '0, '0);
        model_rdata[1] = 32'h2;
        @(negedge clk);
        checkOutput("b2b_end", 32'(bus0.ready_o), 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
        $display("[TB] misaligned write suppressed");
        applyStimulus(0, 1'b1, 32'h20, 32'h00000077);
        applyStimulus(0, 1'b1, 32'h22, 32'h00000055);
        applyStimulus(0, 1'b0, 32'h20, 32'h0);
        checkOutput("misaligned_old_value", bus2.rdata_o, 32'h00000077);
`endif

        $display("[TB] randomized accesses");
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                applyStimulus(s, 1'b1, 32'h100 + 32'(4 * i), $urandom);
            end
        end
        for (int n = 0; n < 60; n++) begin
            int sel;
            sel = int'($urandom_range(0, 1));
            a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3) << 12)
                + 32'($urandom_range(0, 3));
            applyStimulus(sel, 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
